// File: rtl/serial_subtractor_if.sv
// ----------------------------------------------------------------------------
// serial_subtractor_if
// Handshake and operand/result bundle for the bit-serial subtractor.
//   start  : request, sampled by the subtractor only while idle
//   a, b   : minuend / subtrahend, captured on the accepted start
//   busy   : high while bits are being processed
//   done   : one-cycle completion pulse
//   diff   : a - b mod 2^WIDTH
//   borrow : final borrow-out (a < b unsigned)
//   ovf    : signed overflow of a - b (0 unless SERIAL_SUBTRACTOR_OVF_EN)
// Modports: master (requester) and slave (subtractor).
// ----------------------------------------------------------------------------
interface serial_subtractor_if #(
    parameter int unsigned WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic             ovf;

    modport master (
        output start, a, b,
        input  busy, done, diff, borrow, ovf
    );

    modport slave (
        input  start, a, b,
        output busy, done, diff, borrow, ovf
    );
endinterface

// File: rtl/serial_subtractor.sv
// ----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial a - b, one bit per clock, LSB first, through a single
// full-subtractor cell with a registered borrow. WIDTH cycles of RUN, one
// DONE cycle carrying the done pulse, then back to IDLE.
//
// Ports:
//   i_clk : rising-edge clock
//   i_rst : synchronous, active-high reset
//   bus   : serial_subtractor_if.slave (start/a/b in, busy/done/diff/
//           borrow/ovf out)
//
// Optional feature macro: SERIAL_SUBTRACTOR_OVF_EN
//   defined     -> ovf reports two's-complement overflow of a - b
//   not defined -> ovf is constant 0 and the MSB capture flops are absent
// ----------------------------------------------------------------------------
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    serial_subtractor_if.slave   bus
);
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_pr;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    // Full-subtractor cell on the current LSBs.
    logic             w_x;
    logic             w_y;
    logic             w_d;
    logic             w_br_next;
    logic [WIDTH-1:0] w_pr_next;
    logic             w_last;

    assign w_x       = r_sa[0];
    assign w_y       = r_sb[0];
    assign w_d       = w_x ^ w_y ^ r_br;
    assign w_br_next = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
    // Result bits enter at the MSB so that after WIDTH shifts bit 0 sits at LSB.
    assign w_pr_next = {w_d, r_pr[WIDTH-1:1]};
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic r_am;
    logic r_bm;
    logic r_ovf;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_am  <= 1'b0;
            r_bm  <= 1'b0;
            r_ovf <= 1'b0;
        end else if (r_state == S_IDLE && bus.start) begin
            r_am <= bus.a[WIDTH-1];
            r_bm <= bus.b[WIDTH-1];
        end else if (r_state == S_RUN && w_last) begin
            // Operand signs differ and the result sign differs from a.
            r_ovf <= (r_am ^ r_bm) & (r_am ^ w_d);
        end
    end

    assign bus.ovf = r_ovf;
`else
    assign bus.ovf = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_sa     <= '0;
            r_sb     <= '0;
            r_pr     <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sa    <= bus.a;
                        r_sb    <= bus.b;
                        r_pr    <= '0;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_pr  <= w_pr_next;
                    r_sa  <= r_sa >> 1;
                    r_sb  <= r_sb >> 1;
                    r_br  <= w_br_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_diff   <= w_pr_next;
                        r_borrow <= w_br_next;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = (r_state == S_RUN);
    assign bus.done   = (r_state == S_DONE);
    assign bus.diff   = r_diff;
    assign bus.borrow = r_borrow;
endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
    localparam int unsigned WIDTH = 8;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       borrow;
        logic       ovf;   // expected when overflow reporting is enabled
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic [7:0] ed,
                          input logic eb, input logic eo);
        int         busy_cnt;
        int         early_done;
        int         diff_moves;
        logic [7:0] diff_hold;
        busy_cnt   = 0;
        early_done = 0;
        diff_moves = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a     = ~av;
        bus.b     = ~bv;
        diff_hold = bus.diff;
        for (int i = 0; i < 8; i++) begin
            if (bus.busy === 1'b1) busy_cnt++;
            if (bus.done !== 1'b0) early_done++;
            if (bus.diff !== diff_hold) diff_moves++;
            @(posedge clk);
            #1;
        end
        check($sformatf("busy_cycles %h-%h", av, bv), busy_cnt, 8);
        check($sformatf("early_done %h-%h", av, bv), early_done, 0);
        check($sformatf("diff_stable_in_run %h-%h", av, bv), diff_moves, 0);
        check($sformatf("done_pulse %h-%h", av, bv), {bus.busy, bus.done}, 2'b01);
        check($sformatf("diff %h-%h", av, bv), bus.diff, ed);
        check($sformatf("borrow %h-%h", av, bv), bus.borrow, eb);
        check($sformatf("ovf %h-%h", av, bv), bus.ovf, OVF_EN ? eo : 1'b0);
        @(posedge clk);
        #1;
        check($sformatf("done_drop %h-%h", av, bv), {bus.busy, bus.done}, 2'b00);
    endtask

    initial begin
        vec_t vecs[8];
        int   dones;
        int   first_done;
        int   accepts;
        int   acc_t[4];
        logic prev_busy;

        vecs[0] = '{a: 8'h05, b: 8'h03, diff: 8'h02, borrow: 1'b0, ovf: 1'b0};
        vecs[1] = '{a: 8'h03, b: 8'h05, diff: 8'hFE, borrow: 1'b1, ovf: 1'b0};
        vecs[2] = '{a: 8'h00, b: 8'h00, diff: 8'h00, borrow: 1'b0, ovf: 1'b0};
        vecs[3] = '{a: 8'h80, b: 8'h01, diff: 8'h7F, borrow: 1'b0, ovf: 1'b1};
        vecs[4] = '{a: 8'h7F, b: 8'hFF, diff: 8'h80, borrow: 1'b1, ovf: 1'b1};
        vecs[5] = '{a: 8'hFF, b: 8'h01, diff: 8'hFE, borrow: 1'b0, ovf: 1'b0};
        vecs[6] = '{a: 8'h00, b: 8'hFF, diff: 8'h01, borrow: 1'b1, ovf: 1'b0};
        vecs[7] = '{a: 8'h10, b: 8'h01, diff: 8'h0F, borrow: 1'b0, ovf: 1'b0};

        n_checks  = 0;
        n_fail    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", bus.busy, 1'b0);
        check("reset_done", bus.done, 1'b0);
        check("reset_diff", bus.diff, 8'h00);
        check("reset_borrow", bus.borrow, 1'b0);
        check("reset_ovf", bus.ovf, 1'b0);
        rst = 1'b0;

        // Table-driven vectors
        for (int v = 0; v < 8; v++) begin
            run_op(vecs[v].a, vecs[v].b, vecs[v].diff, vecs[v].borrow, vecs[v].ovf);
        end

        // start pulses during RUN and during DONE are ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h10;
        bus.b     = 8'h01;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        dones      = 0;
        first_done = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus.start = (c == 3 || c == 9);
            bus.a     = 8'hFF;
            bus.b     = 8'h00;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                dones++;
                if (first_done < 0) first_done = c;
            end
        end
        check("ignored_start_done_count", dones, 1);
        check("ignored_start_done_cycle", first_done, 8);
        check("ignored_start_diff", bus.diff, 8'h0F);

        // start held high: accepted every WIDTH+2 cycles
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h05;
        bus.b     = 8'h03;
        accepts   = 0;
        prev_busy = 1'b0;
        for (int t = 0; t < 35; t++) begin
            @(posedge clk);
            #1;
            if (bus.busy === 1'b1 && prev_busy === 1'b0) begin
                if (accepts < 4) acc_t[accepts] = t;
                accepts++;
            end
            prev_busy = bus.busy;
        end
        bus.start = 1'b0;
        check("held_start_accepts", accepts, 4);
        check("held_start_gap1", acc_t[1] - acc_t[0], 10);
        check("held_start_gap2", acc_t[2] - acc_t[1], 10);
        check("held_start_gap3", acc_t[3] - acc_t[2], 10);
        repeat (12) @(posedge clk);
        #1;
        check("held_start_diff", bus.diff, 8'h02);

        // Reset in the 4th RUN cycle aborts the operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h55;
        bus.b     = 8'h11;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_diff", bus.diff, 8'h00);
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        check("abort_no_done", dones, 0);
        check("abort_diff_held", bus.diff, 8'h00);
        run_op(8'h55, 8'h11, 8'h44, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial unsigned/two's-complement subtractor computing `a - b` one bit per clock, LSB first. It uses a single full-subtractor cell with a registered borrow. It is the inverse-direction companion to the team's ripple full-adder datapath, for area-constrained arithmetic paths where WIDTH cycles of latency are acceptable. Operands are captured on a start handshake, and the result is presented with a one-cycle done pulse.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on the accepted start
- b  input  WIDTH  subtrahend; captured on the accepted start
- busy  output  1  high while bits are being processed (RUN)
- done  output  1  one-cycle pulse; diff/borrow/ovf are final
- diff  output  WIDTH  registered result, `a - b` mod 2^WIDTH
- borrow  output  1  final borrow-out (1 when a < b unsigned)
- ovf  output  1  signed overflow flag (see Configuration)

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - start=1 at an edge: load shift registers sa<=a, sb<=b, clear the borrow flop br<=0 and bit counter cnt<=0, go to RUN.
  - start=0: stay in IDLE.
- **RUN**, each edge:
  - Compute, with x=sa[0], y=sb[0]:
    - d = x^y^br
    - br_next = (~x&y) | (~(x^y)&br)
  - Shift d into the MSB of the partial-result register pr (shift right).
  - Shift sa and sb right by one; br<=br_next; cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: load diff<=final pr (including this d), borrow<=br_next, ovf per Configuration, then go to DONE.
- **DONE**: done=1 for exactly one cycle; the next edge always goes to IDLE.
- start is ignored in RUN and DONE; there is no queueing.
- a and b may change freely after the accepted start edge.
- diff, borrow and ovf change only on the RUN→DONE edge. They hold their value through IDLE until the next completion.
- Partial results are never visible on diff.
- Arithmetic: diff equals (a - b) mod 2^WIDTH; borrow equals (a < b) unsigned.

## Timing
- Reset values: state=IDLE, busy=0, done=0, diff=0, borrow=0, ovf=0; internal sa, sb, pr, br, cnt are all 0.
- rst has priority over every other input at any edge.
- A reset mid-RUN aborts the operation: no done pulse, and outputs return to their reset values.
- busy and done are decoded from registered state, with no combinational path from start.
- For start accepted at edge k:
  - busy=1 after edges k..k+WIDTH-1 (WIDTH cycles).
  - done=1 in the cycle after edge k+WIDTH.
  - Results are valid from edge k+WIDTH.
- Total latency from the accepting edge to done is WIDTH+1 cycles.
- Back-to-back: start held high continuously is next accepted at edge k+WIDTH+2, so throughput is one operation per WIDTH+2 cycles.

## Configuration
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- **Defined**
  - Capture the operand MSBs am=a[WIDTH-1] and bm=b[WIDTH-1] on start.
  - On completion, ovf <= (am^bm) & (am^diff_final[WIDTH-1]), i.e. two's-complement overflow of a - b.
- **Not defined**
  - ovf is tied to constant 0, and no MSB capture registers exist.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=8.
- **Reset:** assert rst for 2 cycles → busy=0, done=0, diff=0x00, borrow=0, ovf=0.
- **Basic subtract:** a=0x05, b=0x03, start one cycle → busy high 8 cycles, done pulse 9 cycles after the accepting edge, diff=0x02, borrow=0, ovf=0.
- **Underflow:** a=0x03, b=0x05 → diff=0xFE, borrow=1, ovf=0. Also a=0x00, b=0x00 → diff=0x00, borrow=0.
- **Signed overflow:** a=0x80, b=0x01 → diff=0x7F, borrow=0.
  - With SERIAL_SUBTRACTOR_OVF_EN: ovf=1.
  - Without it: ovf=0.
  - Also a=0x7F, b=0xFF → diff=0x80, borrow=1, ovf=1 (macro defined).
- **Ignored start:** start a=0x10, b=0x01; then pulse start with a=0xFF, b=0x00 during RUN, and again in DONE → exactly one done, diff=0x0F. Holding start high yields acceptance exactly every 10 cycles.
- **Reset mid-operation:** start a=0x55, b=0x11; assert rst at the 4th RUN cycle → no done pulse, diff=0x00. A subsequent start a=0x55, b=0x11 → diff=0x44, borrow=0.
